// File: rtl/idex_pipe_stage_if.sv
// Decode-to-execute bus for the ID/EX pipeline register.
// Stats counters exist only when IDEX_STATS_EN is defined.
interface idex_pipe_stage_if #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned NUM_OPS  = 4,
  parameter int unsigned NUM_TAGS = 2,
  parameter int unsigned TAG_W    = 4,
  parameter int unsigned CTRL_W   = 12
`ifdef IDEX_STATS_EN
  ,
  parameter int unsigned CNT_W    = 16
`endif
);
  localparam int unsigned OPS_W  = NUM_OPS * DATA_W;
  localparam int unsigned TAGS_W = NUM_TAGS * TAG_W;

  logic              stall_i;
  logic              flush_i;
  logic              valid_i;
  logic [CTRL_W-1:0] ctrl_i;
  logic [OPS_W-1:0]  data_i;
  logic [TAGS_W-1:0] tag_i;
  logic [TAG_W-1:0]  dest_i;

  logic              valid_o;
  logic [CTRL_W-1:0] ctrl_o;
  logic [OPS_W-1:0]  data_o;
  logic [TAGS_W-1:0] tag_o;
  logic [TAG_W-1:0]  dest_o;
  logic              stall_timeout_o;
`ifdef IDEX_STATS_EN
  logic [CNT_W-1:0]  bubble_cnt_o;
  logic [CNT_W-1:0]  stall_cnt_o;
`endif

  // Decode side / hazard + branch units drive the inputs
  modport master (
    output stall_i, flush_i, valid_i, ctrl_i, data_i, tag_i, dest_i,
    input  valid_o, ctrl_o, data_o, tag_o, dest_o, stall_timeout_o
`ifdef IDEX_STATS_EN
    ,
    input  bubble_cnt_o, stall_cnt_o
`endif
  );

  // Pipeline register side
  modport slave (
    input  stall_i, flush_i, valid_i, ctrl_i, data_i, tag_i, dest_i,
    output valid_o, ctrl_o, data_o, tag_o, dest_o, stall_timeout_o
`ifdef IDEX_STATS_EN
    ,
    output bubble_cnt_o, stall_cnt_o
`endif
  );

endinterface

// File: rtl/idex_pipe_stage.sv
// ID/EX pipeline register with valid bit, stall hold, flush bubble and stall watchdog.
// Define IDEX_STATS_EN to add saturating bubble/stall statistics counters.
module idex_pipe_stage #(
  parameter int unsigned       DATA_W      = 16,
  parameter int unsigned       NUM_OPS     = 4,
  parameter int unsigned       NUM_TAGS    = 2,
  parameter int unsigned       TAG_W       = 4,
  parameter int unsigned       CTRL_W      = 12,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
  parameter int unsigned       MAX_STALL   = 15
`ifdef IDEX_STATS_EN
  ,
  parameter int unsigned       CNT_W       = 16
`endif
) (
  input logic               clk,
  input logic               rst_n,
  idex_pipe_stage_if.slave  bus
);

  localparam int unsigned OPS_W   = NUM_OPS * DATA_W;
  localparam int unsigned TAGS_W  = NUM_TAGS * TAG_W;
  localparam int unsigned STALL_W = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(MAX_STALL);

  logic              valid_q,   valid_d;
  logic [CTRL_W-1:0] ctrl_q,    ctrl_d;
  logic [OPS_W-1:0]  data_q,    data_d;
  logic [TAGS_W-1:0] tag_q,     tag_d;
  logic [TAG_W-1:0]  dest_q,    dest_d;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic              timeout_q, timeout_d;

  logic              hold_c;

  // Flush wins over stall; a stall only counts when no flush is present
  assign hold_c = bus.stall_i & ~bus.flush_i;

  // Next-state for the payload registers
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    tag_d   = tag_q;
    dest_d  = dest_q;

    if (bus.flush_i) begin
      valid_d = 1'b0;
      ctrl_d  = CTRL_BUBBLE;
      tag_d   = '0;
      dest_d  = '0;
    end else if (!bus.stall_i) begin
      valid_d = bus.valid_i;
      data_d  = bus.data_i;
      if (bus.valid_i) begin
        ctrl_d = bus.ctrl_i;
        tag_d  = bus.tag_i;
        dest_d = bus.dest_i;
      end else begin
        // Invalid slot must not leak side effects or forwarding matches downstream
        ctrl_d = CTRL_BUBBLE;
        tag_d  = '0;
        dest_d = '0;
      end
    end
  end

  // Watchdog: saturating count of consecutive stall cycles
  always_comb begin
    stall_cnt_d = '0;
    if (hold_c) begin
      stall_cnt_d = (stall_cnt_q >= STALL_MAX) ? STALL_MAX : stall_cnt_q + STALL_W'(1);
    end
    timeout_d = (stall_cnt_d == STALL_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      ctrl_q      <= CTRL_BUBBLE;
      data_q      <= '0;
      tag_q       <= '0;
      dest_q      <= '0;
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      ctrl_q      <= ctrl_d;
      data_q      <= data_d;
      tag_q       <= tag_d;
      dest_q      <= dest_d;
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.valid_o         = valid_q;
  assign bus.ctrl_o          = ctrl_q;
  assign bus.data_o          = data_q;
  assign bus.tag_o           = tag_q;
  assign bus.dest_o          = dest_q;
  assign bus.stall_timeout_o = timeout_q;

`ifdef IDEX_STATS_EN
  logic [CNT_W-1:0] bubble_stat_q, bubble_stat_d;
  logic [CNT_W-1:0] stall_stat_q,  stall_stat_d;
  logic             bubble_load_c;

  // A bubble enters on flush or on a load of an invalid slot
  assign bubble_load_c = bus.flush_i | (~bus.stall_i & ~bus.valid_i);

  always_comb begin
    bubble_stat_d = bubble_stat_q;
    stall_stat_d  = stall_stat_q;
    if (bubble_load_c && (bubble_stat_q != '1)) begin
      bubble_stat_d = bubble_stat_q + CNT_W'(1);
    end
    if (hold_c && (stall_stat_q != '1)) begin
      stall_stat_d = stall_stat_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_stat_q <= '0;
      stall_stat_q  <= '0;
    end else begin
      bubble_stat_q <= bubble_stat_d;
      stall_stat_q  <= stall_stat_d;
    end
  end

  assign bus.bubble_cnt_o = bubble_stat_q;
  assign bus.stall_cnt_o  = stall_stat_q;
`endif

endmodule
